// File: rtl/ddr3_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_write_arbiter
// Purpose  : Round-robin, burst-granular sharing of one Avalon-MM DDR3 write
//            port between two writers on the ddr3_clk domain.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_write_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      ddr3_clk,
    input  logic                      ddr3clk_reset,
    input  logic [1:0][26:0]          req_write_address,
    input  logic [1:0][255:0]         req_write_data,
    input  logic [1:0]                req_write,
    input  logic [1:0][3:0]           req_burstcount,
    output logic [1:0]                req_waitrequest,
    output logic [26:0]               ddr3_write_address,
    output logic [255:0]              ddr3_write_data,
    output logic                      ddr3_write,
    output logic [3:0]                ddr3_burstcount,
    input  logic                      ddr3_waitrequest,
    output logic                      grant_valid,
    output logic                      grant_id,
    output logic                      burst_done,
    output logic [1:0][CNT_WIDTH-1:0] burst_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [3:0] C_MAX_BC = 4'(MAX_BURST);

    state_t                    state_q;
    logic                      grant_valid_q;
    logic                      grant_id_q;
    logic                      last_grant_q;
    logic                      burst_done_q;
    logic [26:0]               addr_q;
    logic [3:0]                bc_q;
    logic [3:0]                beats_left_q;
    logic [1:0][CNT_WIDTH-1:0] burst_count_q;

    logic       w_busy;
    logic       w_winner;
    logic [3:0] w_req_bc;
    logic [3:0] w_bc_d;
    logic [3:0] w_beats_d;
    logic       w_accept;

    // With both requesting, the one that did not own the previous burst wins.
    always_comb begin
        w_winner  = (req_write == 2'b11) ? ~last_grant_q : req_write[1];
        w_req_bc  = req_burstcount[w_winner];
        w_bc_d    = (w_req_bc > C_MAX_BC) ? C_MAX_BC : w_req_bc;
        w_beats_d = (w_bc_d == 4'd0) ? 4'd1 : w_bc_d;
    end

    assign w_busy          = (state_q == ST_BURST);
    assign ddr3_write      = w_busy & req_write[grant_id_q];
    assign ddr3_write_data = req_write_data[grant_id_q];
    assign w_accept        = ddr3_write & ~ddr3_waitrequest;

    always_comb begin
        req_waitrequest = 2'b11;
        if (w_busy) begin
            req_waitrequest[grant_id_q] = ddr3_waitrequest;
        end
    end

    always_ff @(posedge ddr3_clk or posedge ddr3clk_reset) begin
        if (ddr3clk_reset) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= 1'b0;
            last_grant_q  <= 1'b1;
            burst_done_q  <= 1'b0;
            addr_q        <= '0;
            bc_q          <= '0;
            beats_left_q  <= '0;
            burst_count_q <= '0;
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_write) begin
                        addr_q        <= req_write_address[w_winner];
                        bc_q          <= w_bc_d;
                        beats_left_q  <= w_beats_d;
                        grant_id_q    <= w_winner;
                        grant_valid_q <= 1'b1;
                        state_q       <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        beats_left_q <= beats_left_q - 4'd1;
                        if (beats_left_q == 4'd1) begin
                            burst_done_q                <= 1'b1;
                            burst_count_q[grant_id_q]   <= burst_count_q[grant_id_q] + CNT_WIDTH'(1);
                            last_grant_q                <= grant_id_q;
                            grant_valid_q               <= 1'b0;
                            state_q                     <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ddr3_write_address = addr_q;
    assign ddr3_burstcount    = bc_q;
    assign grant_valid        = grant_valid_q;
    assign grant_id           = grant_id_q;
    assign burst_done         = burst_done_q;
    assign burst_count        = burst_count_q;

endmodule
`default_nettype wire

// File: doc/ddr3_write_arbiter.md
Name: ddr3_write_arbiter

Overview:
Shares one Avalon-MM DDR3 write port between two ddr3 writer instances, for example the left and right camera gray-input writers. It grants the port at burst granularity with round-robin priority and holds the grant until every beat of the burst is accepted. It sits between the writers and the DDR3 controller, on the ddr3_clk domain.

Parameters:
max_burst, 8, largest legal burstcount; burstcount is 4 bits wide, so max_burst ≤ 15
cnt_width, 16, width of per-requester completed-burst counters

Ports:
ddr3_clk  in  1  clock
ddr3clk_reset  in  1  reset, asynchronous, active-high
req_write_address  in  2x27  per-requester word address (index 0/1)
req_write_data  in  2x256  per-requester write data
req_write  in  2  per-requester write request
req_burstcount  in  2x4  per-requester burst length
req_waitrequest  out  2  per-requester waitrequest
ddr3_write_address  out  27  to controller
ddr3_write_data  out  256  to controller
ddr3_write  out  1  to controller
ddr3_burstcount  out  4  to controller
ddr3_waitrequest  in  1  from controller
grant_valid  out  1  a burst is in progress
grant_id  out  1  owner of the current or last burst
burst_done  out  1  one-cycle pulse when the last beat of a burst is accepted
burst_count  out  2xcnt_width  completed bursts per requester, wrapping

Behaviour:
- Reset (asynchronous, active-high):
  - state=ST_IDLE, grant_valid=0, grant_id=0, last_grant=1 so requester 0 wins first.
  - ddr3_write=0, ddr3_write_address=0, ddr3_burstcount=0, burst_done=0.
  - burst_count=0 for both requesters, req_waitrequest=2'b11.
  - Reset mid-burst abandons the burst immediately; there is no drain. The controller side must be reset together.
- ST_IDLE:
  - req_waitrequest=2'b11, ddr3_write=0.
  - If any req_write is high, pick the winner:
    - only one requester asserting: that one wins;
    - both asserting: the one != last_grant wins.
  - Latch the winner's address and burstcount into the ddr3_write_address/ddr3_burstcount registers.
  - Load beats_left = burstcount, with burstcount 0 treated as 1.
  - Set grant_id = winner, grant_valid=1, go to ST_BURST.
  - No beat is accepted in the ST_IDLE cycle, so there is 1 cycle of arbitration latency.
- ST_BURST (combinational mux on the granted index g):
  - ddr3_write = req_write[g]; ddr3_write_data = req_write_data[g].
  - req_waitrequest[g] = ddr3_waitrequest; req_waitrequest[!g] = 1.
  - ddr3_write_address and ddr3_burstcount stay at their latched values for the whole burst (Avalon burst semantics). Requester address changes mid-burst are ignored.
  - Beat accepted = ddr3_write && !ddr3_waitrequest; each accepted beat decrements beats_left.
  - If req_write[g] drops mid-burst: ddr3_write=0, the counter holds, and the grant is kept. There is no timeout.
  - Final beat (beats_left==1) accepted:
    - burst_done=1 for one cycle; burst_count[g] += 1, wrapping at 2^cnt_width.
    - last_grant=g, grant_valid=0, go to ST_IDLE.
- Throughput: back-to-back bursts are separated by exactly one ST_IDLE cycle.
- A requester that keeps req_write high while losing arbitration sees waitrequest=1 until it is granted. Its data must be held per Avalon rules.
- A burstcount above max_burst is clamped to max_burst for both beats_left and ddr3_burstcount.
- The arbiter does not inspect or alter data bits; SOF flags embedded in the data pass through untouched.

Test Plan:
- Single requester: req0 issues a burst of 8 at address 0x100 with waitrequest=0.
  - Required: 1 idle cycle, then 8 consecutive beats with address 0x100 and burstcount 8 throughout.
  - burst_done pulses once; burst_count[0]=1; req_waitrequest[1] stays 1.
- Contention: both requesters assert from reset and each issues 3 bursts of 8.
  - Required grant order 0,1,0,1,0,1 with each burst contiguous.
  - Final burst_count = {3,3}; no beat interleaving between requesters.
- Backpressure: ddr3_waitrequest toggles 1,0,1,0 during a burst of 4.
  - Required: exactly 4 accepted beats, data in order, req_waitrequest[g] mirrors ddr3_waitrequest.
- Requester stall: req1 drops req_write after 3 of 8 beats for 5 cycles, while req0 is requesting.
  - Required: the grant stays on 1, ddr3_write=0 during the gap, and the remaining 5 beats complete before req0 is granted.
- Edge burstcounts: burstcount 0 gives 1 beat; burstcount 15 with max_burst=8 gives 8 beats with ddr3_burstcount=8.
- Reset mid-burst: assert ddr3clk_reset asynchronously after beat 2 of 8.
  - Required: ddr3_write=0 and req_waitrequest=2'b11 immediately, counters at 0, and requester 0 wins the first grant after reset release.
